pe_vec: RTL
===========

Name: pe_vec

Overview:
- Next-generation systolic processing element for the matrix-multiply array.
- Each cycle it computes a LANES-wide dot product of packed operand vectors and accumulates it in a 2-stage pipeline.
- Signed/unsigned mode and saturate/wrap mode are selectable at runtime; a sticky overflow flag reports accumulator overflow.
- Results leave through a shift-chain drain, so a whole PE row unloads over one shared bus while the next C-block accumulates without a bubble.

Parameters:
- W, 8: element width in bits.
- LANES, 4: elements per operand vector, i.e. multipliers per PE.
- ACCW, 32: accumulator width. Elaboration fails unless ACCW >= 2*W + clog2(LANES).
- SAT_EN, 1: when 0, the saturation logic is not built and sat_mode is ignored (always wraps).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- a_in  in  LANES*W  packed A vector; lane i is bits [i*W +: W].
- a_valid_in  in  1  A vector valid.
- b_in  in  LANES*W  packed B vector.
- b_valid_in  in  1  B vector valid.
- a_out  out  LANES*W  A forwarded to the east neighbour.
- a_valid_out  out  1  forwarded A valid.
- b_out  out  LANES*W  B forwarded to the south neighbour.
- b_valid_out  out  1  forwarded B valid.
- signed_mode  in  1  1 = two's-complement operands; sampled with the operands.
- sat_mode  in  1  1 = saturate the accumulator; sampled at stage 2.
- acc_clear  in  1  clear-and-load at the C-block boundary.
- drain_load  in  1  capture the accumulator into the drain register.
- drain_shift  in  1  shift the drain chain by one.
- drain_in  in  ACCW  drain data from the upstream PE.
- drain_valid_in  in  1  upstream drain valid.
- drain_out  out  ACCW  drain register.
- drain_valid_out  out  1  drain register valid.
- ovf_flag  out  1  sticky overflow for the current block.

Behaviour:
- Reset: every register and every output is 0 on the first clk edge with rst=1. Reset mid-operation discards all in-flight data (stage-1 products, accumulator, drain register).
- Forwarding: a_out, a_valid_out, b_out, b_valid_out are registered copies of the inputs, 1-cycle latency, updated every cycle regardless of valid.
- Stage 1:
  - mac = a_valid_in & b_valid_in.
  - Each lane product is W x W, sign- or zero-extended per signed_mode.
  - Lane products are summed at width PW = 2W + clog2(LANES); this sum cannot overflow.
  - Registers: s1_sum, s1_valid = mac, s1_signed = signed_mode.
- Stage 2 (accumulator acc):
  - Addend = s1_sum extended to ACCW (sign-extended if s1_signed, else zero-extended).
  - acc_clear=1: acc <= s1_valid ? addend : 0, and ovf_flag <= 0.
    - Rule: acc_clear is asserted one cycle after the first input of a new block, so no product is lost.
  - Otherwise, if s1_valid: acc <= acc + addend with overflow handling as below.
  - Otherwise acc holds.
- Latency: an operand pair accepted at edge t is reflected in acc after edge t+2.
- Overflow:
  - Signed: the true sum falls outside [-2^(ACCW-1), 2^(ACCW-1)-1].
  - Unsigned: carry out of bit ACCW-1.
  - On overflow ovf_flag <= 1 (sticky until acc_clear or rst).
  - sat_mode=1 and SAT_EN=1: acc clamps to the violated bound; unsigned clamps to 2^ACCW-1.
  - Otherwise acc wraps modulo 2^ACCW.
  - A mode change mid-block is legal; each addend uses the mode in force at its own stage.
- Drain, priority load > shift > hold:
  - drain_load: drain_out <= acc value before this edge's update; drain_valid_out <= 1.
  - drain_shift only: drain_out <= drain_in; drain_valid_out <= drain_valid_in.
  - Neither: hold.
  - drain_load together with acc_clear captures the finished block while the new block starts loading.
- Chaining: drain_out connects to the next PE's drain_in, and the chain head has drain_valid_in=0. After N shifts, an N-PE row has emptied and all drain_valid_out are 0.

Test Plan:
- Signed accumulate (defaults): a={1,-2,3,-4}, b={5,6,-7,8}, valid for 3 cycles from edge t -> acc=-60/-120/-180 after edges t+2/t+3/t+4; ovf_flag=0.
- Unsigned mode: all lanes a=b=255 for 2 cycles -> acc=260100 then 520200, no ovf; the same data with signed_mode=1 gives 4 then 8.
- Saturation (ACCW=20, signed): all lanes a=b=-128 (+65536/cycle) for 8 cycles -> final acc=524287, ovf_flag=1. Repeat with sat_mode=0 -> acc=-524288, ovf_flag=1.
- Seamless block swap: stream 4 cycles of +10 per cycle, then new-block data at +1 per cycle. Assert acc_clear and drain_load in the cycle after the first new input -> drain_out=40, drain_valid_out=1, acc=1 then 2 with no gap; ovf cleared.
- Drain chain: 3 PEs holding 7/8/9, drain_load, then 3 drain_shift cycles -> tail drain_out sequence 9,8,7 valid; the 4th cycle shows drain_valid_out=0 everywhere. drain_load+drain_shift together -> load wins.
- Reset mid-op: rst for 1 cycle while s1_valid=1 and drain_valid_out=1 -> next cycle acc=0, all outputs 0, and the in-flight product never appears in acc.

Source files
------------

// File: rtl/pe_vec.sv
// pe_vec: systolic processing element for the matrix-multiply array.
//
// Each cycle the element multiplies two packed LANES-wide operand vectors lane
// by lane, sums the products (stage 1) and adds the sum into a wide
// accumulator (stage 2). Operands are forwarded east/south with one cycle of
// latency. A finished accumulator value is captured into a drain register that
// is chained PE to PE, so a row unloads over one bus while the next block
// accumulates.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   a_in/a_valid_in                packed A vector (lane i = bits [i*W +: W])
//   b_in/b_valid_in                packed B vector
//   a_out/a_valid_out              A forwarded east (registered)
//   b_out/b_valid_out              B forwarded south (registered)
//   signed_mode                    1 = two's-complement operands (stage 1)
//   sat_mode                       1 = saturate on overflow (stage 2)
//   acc_clear                      start a new block: load the addend, clear ovf
//   drain_load                     capture the accumulator into the drain reg
//   drain_shift                    take drain_in/drain_valid_in (load wins)
//   drain_in/drain_valid_in        drain data from the upstream PE
//   drain_out/drain_valid_out      drain register
//   ovf_flag                       sticky overflow for the current block
module pe_vec #(
    parameter int W      = 8,
    parameter int LANES  = 4,
    parameter int ACCW   = 32,
    parameter int SAT_EN = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [LANES*W-1:0]   a_in,
    input  logic                 a_valid_in,
    input  logic [LANES*W-1:0]   b_in,
    input  logic                 b_valid_in,
    output logic [LANES*W-1:0]   a_out,
    output logic                 a_valid_out,
    output logic [LANES*W-1:0]   b_out,
    output logic                 b_valid_out,
    input  logic                 signed_mode,
    input  logic                 sat_mode,
    input  logic                 acc_clear,
    input  logic                 drain_load,
    input  logic                 drain_shift,
    input  logic [ACCW-1:0]      drain_in,
    input  logic                 drain_valid_in,
    output logic [ACCW-1:0]      drain_out,
    output logic                 drain_valid_out,
    output logic                 ovf_flag
);

    // Width at which the lane products are summed; this sum cannot overflow.
    localparam int PW = 2 * W + $clog2(LANES);
    localparam bit SAT_BUILT = (SAT_EN != 0);

    localparam logic [ACCW-1:0] SMAX = {1'b0, {(ACCW-1){1'b1}}};
    localparam logic [ACCW-1:0] SMIN = {1'b1, {(ACCW-1){1'b0}}};
    localparam logic [ACCW-1:0] UMAX = {ACCW{1'b1}};

    generate
        if (ACCW < PW) begin : g_accw_check
            $error("pe_vec: ACCW must be at least 2*W + clog2(LANES)");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [LANES*W-1:0] a_fwd_reg, b_fwd_reg;
    logic               a_vld_reg, b_vld_reg;
    logic [PW-1:0]      s1_sum_reg, s1_sum_next;
    logic               s1_valid_reg, s1_signed_reg;
    logic [ACCW-1:0]    acc_reg, acc_next;
    logic               ovf_reg, ovf_next;
    logic [ACCW-1:0]    drain_reg, drain_next;
    logic               drain_valid_reg, drain_valid_next;

    // ------------------------------------------------------------------
    // Stage 1: per-lane products, extended to PW before multiplying so the
    // truncated PW-bit product is exact in either mode.
    // ------------------------------------------------------------------
    logic [PW-1:0] prod [LANES];

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            logic [W-1:0]  a_lane, b_lane;
            logic [PW-1:0] a_ext, b_ext;
            assign a_lane    = a_in[gi*W +: W];
            assign b_lane    = b_in[gi*W +: W];
            assign a_ext     = {{(PW-W){signed_mode & a_lane[W-1]}}, a_lane};
            assign b_ext     = {{(PW-W){signed_mode & b_lane[W-1]}}, b_lane};
            assign prod[gi]  = a_ext * b_ext;
        end
    endgenerate

    always_comb begin
        s1_sum_next = '0;
        for (int i = 0; i < LANES; i++) begin
            s1_sum_next = s1_sum_next + prod[i];
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: accumulate with overflow detection. The sum is formed one bit
    // wider than the accumulator; the extra bit is the carry (unsigned) or
    // the extended sign (signed).
    // ------------------------------------------------------------------
    logic                 sign_fill;
    logic [ACCW+PW-1:0]   addend_wide;
    logic [ACCW-1:0]      addend;
    logic [ACCW:0]        sum_ext;
    logic                 add_ovf;
    logic                 sat_active;
    logic [ACCW-1:0]      clamp_val;

    assign sign_fill   = s1_signed_reg & s1_sum_reg[PW-1];
    assign addend_wide = {{ACCW{sign_fill}}, s1_sum_reg};
    assign addend      = addend_wide[ACCW-1:0];

    assign sum_ext = {s1_signed_reg & acc_reg[ACCW-1], acc_reg}
                   + {s1_signed_reg & addend[ACCW-1], addend};

    assign add_ovf = s1_signed_reg ? (sum_ext[ACCW] ^ sum_ext[ACCW-1])
                                   : sum_ext[ACCW];

    // Signed overflow can only go in the direction of the addend's sign;
    // unsigned overflow is always upward.
    assign clamp_val  = s1_signed_reg ? (addend[ACCW-1] ? SMIN : SMAX) : UMAX;
    assign sat_active = SAT_BUILT && sat_mode;

    always_comb begin
        acc_next = acc_reg;
        ovf_next = ovf_reg;
        if (acc_clear) begin
            // The first product of the new block lands here, so load it.
            acc_next = s1_valid_reg ? addend : '0;
            ovf_next = 1'b0;
        end else if (s1_valid_reg) begin
            acc_next = (add_ovf && sat_active) ? clamp_val : sum_ext[ACCW-1:0];
            if (add_ovf) begin
                ovf_next = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Drain: load captures the pre-update accumulator, so a load in the same
    // cycle as acc_clear takes the finished block.
    // ------------------------------------------------------------------
    always_comb begin
        drain_next       = drain_reg;
        drain_valid_next = drain_valid_reg;
        if (drain_load) begin
            drain_next       = acc_reg;
            drain_valid_next = 1'b1;
        end else if (drain_shift) begin
            drain_next       = drain_in;
            drain_valid_next = drain_valid_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_fwd_reg       <= '0;
            b_fwd_reg       <= '0;
            a_vld_reg       <= 1'b0;
            b_vld_reg       <= 1'b0;
            s1_sum_reg      <= '0;
            s1_valid_reg    <= 1'b0;
            s1_signed_reg   <= 1'b0;
            acc_reg         <= '0;
            ovf_reg         <= 1'b0;
            drain_reg       <= '0;
            drain_valid_reg <= 1'b0;
        end else begin
            a_fwd_reg       <= a_in;
            b_fwd_reg       <= b_in;
            a_vld_reg       <= a_valid_in;
            b_vld_reg       <= b_valid_in;
            s1_sum_reg      <= s1_sum_next;
            s1_valid_reg    <= a_valid_in & b_valid_in;
            s1_signed_reg   <= signed_mode;
            acc_reg         <= acc_next;
            ovf_reg         <= ovf_next;
            drain_reg       <= drain_next;
            drain_valid_reg <= drain_valid_next;
        end
    end

    assign a_out           = a_fwd_reg;
    assign a_valid_out     = a_vld_reg;
    assign b_out           = b_fwd_reg;
    assign b_valid_out     = b_vld_reg;
    assign drain_out       = drain_reg;
    assign drain_valid_out = drain_valid_reg;
    assign ovf_flag        = ovf_reg;

endmodule
